// File: rtl/tt_delta_pkg.sv
// Shared types and constants for the delta decoder: FSM states, FIFO geometry, uio bit map.
package tt_delta_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;

    // uio_in bit positions
    localparam int unsigned UIO_IN_VALID  = 0;
    localparam int unsigned UIO_IN_LOAD   = 1;
    localparam int unsigned UIO_CLEAR     = 2;
    localparam int unsigned UIO_OUT_READY = 3;

    // uio_out bit positions
    localparam int unsigned UIO_IN_READY  = 4;
    localparam int unsigned UIO_OUT_VALID = 5;
    localparam int unsigned UIO_OVF       = 6;
    localparam int unsigned UIO_ERR       = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic              load;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/delta_fifo.sv
// Four-entry FIFO of {load, data} with occupancy count and synchronous flush.
module delta_fifo
    import tt_delta_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fifo_entry_t      wdata,
    output fifo_entry_t      rdata,
    output logic [CNT_W-1:0] count
);

    fifo_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is refused even if a pop happens in the same cycle.
    assign push_ok = push && (count < CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/tt_um_delta_decoder.sv
// Delta decoder: rebuilds x[n] = x[n-1] + d[n] from a buffered delta/load stream.
// Define DELTA_DECODER_SAT_EN to clamp out-of-range adds to 0/255 instead of wrapping.
module tt_um_delta_decoder
    import tt_delta_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic              in_valid;
    logic              in_load;
    logic              clear;
    logic              out_ready;
    logic              in_ready;
    logic              push;
    logic              pop;
    logic              flush;
    logic [CNT_W-1:0]  count;
    fifo_entry_t       wr_entry;
    fifo_entry_t       rd_entry;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic              out_valid;
    logic              ovf;
    logic              err;

    logic [DATA_W+1:0] sum;
    logic              add_ovf;
    logic [DATA_W-1:0] add_res;
    logic              unused_uio;

    assign in_valid  = uio_in[UIO_IN_VALID];
    assign in_load   = uio_in[UIO_IN_LOAD];
    assign clear     = uio_in[UIO_CLEAR];
    assign out_ready = uio_in[UIO_OUT_READY];
    assign unused_uio = &{1'b0, uio_in[7:4]};

    assign in_ready = ena && (count < CNT_W'(FIFO_DEPTH));
    assign push     = in_ready && in_valid && !clear;
    assign pop      = ena && !clear && (count != '0) && (!out_valid || out_ready);
    assign flush    = ena && clear;

    assign wr_entry.load = in_load;
    assign wr_entry.data = ui_in;

    delta_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (count)
    );

    // Unsigned acc plus sign-extended delta; any bit above [7] means out of 0..255.
    always_comb begin
        sum     = {2'b00, acc} + {{2{rd_entry.data[DATA_W-1]}}, rd_entry.data};
        add_ovf = sum[DATA_W+1] || sum[DATA_W];
`ifdef DELTA_DECODER_SAT_EN
        if (sum[DATA_W+1]) begin
            add_res = '0;
        end else if (sum[DATA_W]) begin
            add_res = '1;
        end else begin
            add_res = sum[DATA_W-1:0];
        end
`else
        add_res = sum[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                state     <= IDLE;
                acc       <= '0;
                out_valid <= 1'b0;
                ovf       <= 1'b0;
                err       <= 1'b0;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (pop) begin
                    if (rd_entry.load) begin
                        acc       <= rd_entry.data;
                        out_valid <= 1'b1;
                        state     <= RUN;
                    end else if (state == RUN) begin
                        acc       <= add_res;
                        out_valid <= 1'b1;
                        if (add_ovf) begin
                            ovf <= 1'b1;
                        end
                    end else begin
                        // Delta with no base yet: drop it and flag the stream as broken.
                        err <= 1'b1;
                    end
                end
            end
        end
    end

    assign uo_out  = acc;
    assign uio_out = {err, ovf, out_valid, in_ready, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_delta_decoder.sv
// Self-checking bench for tt_um_delta_decoder: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_tt_um_delta_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    logic [8:0] m_q[$];
    int         m_acc;
    bit         m_ov;
    bit         m_ovf;
    bit         m_err;
    bit         m_run;

    tt_um_delta_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_acc = 0;
        m_ov  = 0;
        m_ovf = 0;
        m_err = 0;
        m_run = 0;
    endtask

    // Next-state of the reference, from the inputs present before the edge.
    task automatic model_step(input bit r, input bit e, input logic [7:0] d,
                              input bit v, input bit ld, input bit clr, input bit ordy);
        bit         do_push;
        bit         do_pop;
        logic [8:0] head;
        int         s;
        if (!r) begin
            model_clear();
        end else if (e) begin
            if (clr) begin
                model_clear();
            end else begin
                do_push = v && (m_q.size() < 4);
                do_pop  = (m_q.size() > 0) && (!m_ov || ordy);
                if (ordy) m_ov = 0;
                if (do_pop) begin
                    head = m_q.pop_front();
                    if (head[8]) begin
                        m_acc = int'(head[7:0]);
                        m_ov  = 1;
                        m_run = 1;
                    end else if (m_run) begin
                        s = m_acc + int'($signed(head[7:0]));
                        if (s < 0 || s > 255) m_ovf = 1;
`ifdef DELTA_DECODER_SAT_EN
                        m_acc = (s < 0) ? 0 : ((s > 255) ? 255 : s);
`else
                        m_acc = s & 255;
`endif
                        m_ov = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                if (do_push) m_q.push_back({ld, d});
            end
        end
    endtask

    // One clock: drive at posedge+1, check in_ready before the edge, outputs after it.
    task automatic cycle(input bit r, input bit e, input logic [7:0] d,
                         input bit v, input bit ld, input bit clr, input bit ordy);
        rst_n  = r;
        ena    = e;
        ui_in  = d;
        uio_in = {4'($urandom), ordy, clr, ld, v};
        #1;
        check("in_ready_pre", int'(uio_out[4]), int'(e && (m_q.size() < 4)));
        model_step(r, e, d, v, ld, clr, ordy);
        @(posedge clk);
        #1;
        check("uo_out", int'(uo_out), m_acc);
        check("out_valid", int'(uio_out[5]), int'(m_ov));
        check("ovf", int'(uio_out[6]), int'(m_ovf));
        check("err", int'(uio_out[7]), int'(m_err));
        check("in_ready_post", int'(uio_out[4]), int'(ena && (m_q.size() < 4)));
        check("uio_low", int'(uio_out[3:0]), 0);
        check("uio_oe", int'(uio_oe), 8'hF0);
    endtask

    task automatic idle(input bit ordy);
        cycle(1, 1, 8'h00, 0, 0, 0, ordy);
    endtask

    task automatic send(input logic [7:0] d, input bit ld, input bit ordy);
        cycle(1, 1, d, 1, ld, 0, ordy);
    endtask

    task automatic do_clear();
        cycle(1, 1, 8'h00, 0, 0, 1, 1);
    endtask

    int         exp_sat;
    logic [7:0] hold_uo;
    logic [7:0] hold_uio;

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Reset state
        cycle(0, 1, 8'h00, 0, 0, 0, 1);
        check("rst_uo", int'(uo_out), 0);
        check("rst_flags", int'(uio_out[7:5]), 0);
        check("rst_in_ready", int'(uio_out[4]), 1);

        // Basic reconstruction: 100, +5, -3
        send(8'd100, 1, 1);
        send(8'd5, 0, 1);
        check("basic_100", int'(uo_out), 100);
        send(8'hFD, 0, 1);
        check("basic_105", int'(uo_out), 105);
        idle(1);
        check("basic_102", int'(uo_out), 102);
        check("basic_ovf", int'(uio_out[6]), 0);
        idle(1);
        check("basic_drop_valid", int'(uio_out[5]), 0);

        // Overflow: 250 + 10
`ifdef DELTA_DECODER_SAT_EN
        exp_sat = 255;
`else
        exp_sat = 4;
`endif
        do_clear();
        send(8'd250, 1, 1);
        send(8'd10, 0, 1);
        idle(1);
        check("ovf_value", int'(uo_out), exp_sat);
        check("ovf_set", int'(uio_out[6]), 1);
        send(8'd1, 0, 1);
        idle(1);
        check("ovf_sticky", int'(uio_out[6]), 1);
        do_clear();
        check("ovf_cleared", int'(uio_out[6]), 0);

        // Delta before any load
        send(8'd7, 0, 1);
        idle(1);
        check("nobase_valid", int'(uio_out[5]), 0);
        check("nobase_err", int'(uio_out[7]), 1);
        send(8'd9, 1, 1);
        idle(1);
        check("nobase_load", int'(uo_out), 9);
        check("nobase_load_valid", int'(uio_out[5]), 1);

        // Backpressure: five pushes with out_ready low, sixth refused, then drain
        do_clear();
        send(8'd10, 1, 0);
        for (int i = 0; i < 4; i++) send(8'd1, 0, 0);
        check("bp_full_ready", int'(uio_out[4]), 0);
        check("bp_head", int'(uo_out), 10);
        send(8'd50, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("bp_drain", int'(uo_out), 11 + i);
            check("bp_drain_valid", int'(uio_out[5]), 1);
        end
        idle(1);
        check("bp_empty_valid", int'(uio_out[5]), 0);
        check("bp_final", int'(uo_out), 14);

        // Clear with simultaneous push and three queued entries
        send(8'd20, 1, 0);
        send(8'd1, 0, 0);
        send(8'd2, 0, 0);
        send(8'd3, 0, 0);
        cycle(1, 1, 8'd40, 1, 1, 1, 0);
        check("clr_uo", int'(uo_out), 0);
        check("clr_flags", int'(uio_out[7:5]), 0);
        idle(1);
        idle(1);
        check("clr_dropped", int'(uio_out[5]), 0);
        send(8'd3, 0, 1);
        idle(1);
        check("clr_idle_err", int'(uio_out[7]), 1);

        // Reset mid-stream, then ena low freezes everything
        do_clear();
        send(8'd30, 1, 0);
        send(8'd2, 0, 0);
        send(8'd2, 0, 0);
        cycle(0, 1, 8'd5, 1, 0, 0, 1);
        check("mid_rst_uo", int'(uo_out), 0);
        check("mid_rst_valid", int'(uio_out[5]), 0);
        idle(1);
        idle(1);
        check("mid_rst_nopartial", int'(uio_out[5]), 0);
        send(8'd60, 1, 0);
        send(8'hF0, 0, 0);
        idle(0);
        hold_uo  = uo_out;
        hold_uio = uio_out;
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'd99, 1, 1, (i == 2), 1);
        check("ena_hold_uo", int'(uo_out), int'(hold_uo));
        check("ena_hold_flags", int'(uio_out[7:5]), int'(hold_uio[7:5]));
        check("ena_in_ready", int'(uio_out[4]), 0);
        idle(1);
        check("ena_resume", int'(uo_out), 60 - 16);

        // Random traffic
        do_clear();
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) != 0),
                  8'($urandom),
                  bit'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_delta_decoder.md
TT_UM_DELTA_DECODER -- requirements
Module: tt_um_delta_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-003 SHALL have port ena, input, 1 bit: design enable; low = freeze all state.
REQ-004 SHALL have port ui_in, input, 8 bits: delta sample, signed two's complement, or absolute base when in_load=1.
REQ-005 SHALL have port uio_in, input, 8 bits: [0] in_valid, [1] in_load, [2] clear, [3] out_ready; [7:4] ignored.
REQ-006 SHALL have port uo_out, output, 8 bits: reconstructed sample x[n].
REQ-007 SHALL have port uio_out, output, 8 bits: [3:0]=0, [4] in_ready, [5] out_valid, [6] ovf (sticky), [7] err (sticky).
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'hF0.

Function
REQ-009 SHALL compute x[n] = x[n-1] + d[n] mod 256, reconstructing the stream whose differences were produced upstream as a - b mod 256.
REQ-010 SHALL buffer inputs in a 4-entry FIFO of {load, data}; in_ready = ena && count<4.
REQ-011 SHALL push on a rising edge where in_valid && in_ready; a push while full SHALL NOT be accepted, even with a simultaneous pop.
REQ-012 SHALL pop one entry per cycle when FIFO is non-empty and output register is empty or out_ready=1.
REQ-013 SHALL implement FSM IDLE/RUN. IDLE: popped delta discarded, err set. Popped load: acc=data, out_valid=1, go RUN.
REQ-014 In RUN, popped delta SHALL give acc=acc+data and out_valid=1. Popped load SHALL give acc=data and out_valid=1 with no ovf update.
REQ-015 SHALL set ovf when a delta add leaves range 0..255: unsigned acc plus sign-extended delta outside 0..255.
REQ-016 out_valid SHALL stay high with uo_out stable until a cycle with out_ready=1; with no pop it SHALL then drop.
REQ-017 Latency: sample accepted at edge k into empty FIFO with out_ready=1 SHALL appear on uo_out with out_valid after edge k+1.
REQ-018 clear=1 SHALL take priority over push/pop: flush FIFO, acc=0, out_valid=0, ovf=0, err=0, state IDLE at next edge.
REQ-019 ena=0 SHALL block push, pop, and clear; all registers hold.

Reset
REQ-020 rst_n=0 at an edge SHALL give: FIFO empty, acc=0, uo_out=0, out_valid=0, ovf=0, err=0, state IDLE. in_ready SHALL follow ena.
REQ-021 Reset mid-stream SHALL discard buffered entries with no partial output.

Configuration
REQ-022 With DELTA_DECODER_SAT_EN defined, delta adds SHALL clamp to 0 or 255 instead of wrapping, and still set ovf.
REQ-023 Without DELTA_DECODER_SAT_EN, delta adds SHALL wrap modulo 256 and set ovf.

Structure
REQ-024 Package tt_delta_pkg SHALL hold the FSM state enum (IDLE, RUN), FIFO_DEPTH=4, and the uio bit-index constants.
REQ-025 The FIFO SHALL be sub-module delta_fifo (4x9 bits, count, push/pop, flush); the accumulator and FSM stay in the top module.

Verification
REQ-026 Load 8'd100, deltas +5, -3 (8'hFD) -> uo_out 100, 105, 102 on successive out_valid; ovf=0.
REQ-027 Load 250, delta +10 -> wrap build: 4, ovf=1. SAT_EN build: 255, ovf=1. Sticky until clear.
REQ-028 Delta 7 sent before any load -> no out_valid, err=1. A following load 9 -> uo_out 9.
REQ-029 out_ready=0, push 5 entries back-to-back -> output register takes 1, FIFO fills 4, in_ready=0, 6th not accepted. Then out_ready=1 drains in order, one per cycle.
REQ-030 Clear and in_valid asserted in the same cycle with 3 entries queued -> FIFO empty, acc=0, flags 0, IDLE, pushed entry dropped.
REQ-031 Assert rst_n=0 for one cycle mid-stream, and hold ena=0 with in_valid=1 -> all outputs per REQ-020; during ena=0 no state change.
